prog_lut_neuron: RTL and testbench
==================================

Name: prog_lut_neuron

Overview:
- Runtime-programmable LUT neuron: the table writer and registered lookup engine counterpart to the fixed ROM-style neuron modules generated per layer.
- A config streamer loads 2^IN_BITS truth-table entries sequentially. A valid/ready inference stream then looks up each input word and returns the registered entry.
- Sits in the HGCAL autoencoder test harness, so neuron tables can be swapped without resynthesis.

Parameters:
- IN_BITS, 8, neuron input word width = table address width (fan-in × input precision).
- OUT_BITS, 2, neuron output precision = table entry width.
- DEPTH, 2**IN_BITS, number of entries (derived; not overridable).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse: begin (or restart) table load at address 0.
- cfg_valid  in  1  cfg_data beat valid.
- cfg_ready  out  1  beat accepted when cfg_valid && cfg_ready.
- cfg_data  in  OUT_BITS  entry for current load address.
- cfg_done  out  1  one-cycle pulse after final entry written.
- table_ok  out  1  level: full table loaded, lookups enabled.
- in_valid  in  1  inference input valid.
- in_ready  out  1  inference input accepted.
- in_data  in  IN_BITS  neuron input word (table address).
- out_valid  out  1  lookup result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_BITS  looked-up entry.

Behaviour:
- Reset values (async, rst_n=0): state=EMPTY, load address=0, cfg_ready=0, cfg_done=0, table_ok=0, in_ready=0, out_valid=0, out_data=0. Table storage is not reset; contents are undefined until loaded.
- FSM states:
  - EMPTY: cfg_ready=0, in_ready=0. cfg_start → LOAD with addr=0.
  - LOAD: cfg_ready=1. Each accepted beat writes table[addr]=cfg_data, then addr+1. Beat accepted at addr=DEPTH-1 → RUN, with cfg_done=1 for exactly the next cycle and table_ok=1 from the next cycle. The address counter is IN_BITS+1 wide, so there is no silent wrap.
  - RUN: table_ok=1, cfg_ready=0. Lookups enabled. cfg_start → LOAD with addr=0, table_ok=0.
- cfg_start in LOAD restarts at addr 0. A beat coincident with cfg_start is discarded (cfg_start has priority).
- cfg_valid outside LOAD is ignored. cfg_data is don't-care when cfg_valid=0.
- Lookup:
  - in_ready = (state==RUN) && !cfg_start && (!out_valid || out_ready).
  - Accept → out_data <= table[in_data] and out_valid <= 1 on the next edge: latency 1 cycle, throughput 1/cycle under continuous out_ready.
  - out_valid && !out_ready: out_data and out_valid hold stable and in_ready=0.
  - out_valid clears on handshake if no new accept that cycle.
- Leaving RUN (cfg_start) while out_valid=1: the pending result is retained until consumed. No new accepts until RUN is re-entered.
- A write and a read of the same address cannot occur in the same cycle (the states are exclusive). No bypass logic is required.
- rst_n asserted mid-load or mid-run: everything aborts immediately, and the block returns to EMPTY requiring a full reload.
- Table indexing is in_data unsigned, bit ordering identical to the generated neuron case tables (M0 value = address).

Decomposition:
- Shared package lut_neuron_pkg: state enum (EMPTY/LOAD/RUN), default IN_BITS/OUT_BITS constants, DEPTH function.
- Sub-module lut_ram_1w1r: DEPTH×OUT_BITS distributed RAM, one sync write port, registered read with enable.
- The top level holds the FSM, load counter and handshake logic.

Test Plan:
- Reset, no cfg_start; drive in_valid=1 with in_data=8'h00 for 10 cycles → in_ready=0, out_valid=0, table_ok=0 throughout.
- Load the 256-entry table with entry[a]=a[1:0]^a[7:6]. Then stream 8'h00, 8'h41, 8'hC3, 8'hFF with out_ready=1:
  - cfg_done pulses once after beat 255.
  - out_data = 2'b00, 2'b00, 2'b00, 2'b00 on consecutive cycles, each one cycle after its accept.
- Same load with cfg_valid toggling 50% randomly → 256 beats accepted exactly, cfg_done one cycle after last, readback of all 256 addresses matches.
- Backpressure: out_ready=0 for 3 cycles after accepting 8'h41 → out_data stable, in_ready=0. Release → next input accepted the same cycle.
- Pulse cfg_start at beat 100 of a load, then load a full all-2'b11 table → every lookup returns 2'b11, and only one cfg_done occurs.
- Assert rst_n=0 in RUN with out_valid=1 → out_valid=0 and table_ok=0 asynchronously. A lookup after release is refused until a reload completes.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// ---------------------------------------------------------------------------
// lut_neuron_pkg
// Shared definitions for the runtime-programmable LUT neuron:
//   - default neuron input width (table address) and output width (entry)
//   - controller state encoding
//   - table depth helper, derived from the address width
// ---------------------------------------------------------------------------
package lut_neuron_pkg;

    localparam int DEF_IN_BITS  = 8;
    localparam int DEF_OUT_BITS = 2;

    // EMPTY: no valid table; LOAD: streaming entries in; RUN: lookups enabled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Number of table entries for a given address width
    function automatic int lut_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_ram_1w1r.sv
// ---------------------------------------------------------------------------
// lut_ram_1w1r
// Table storage for the LUT neuron: 2^ADDR_BITS x DATA_BITS memory with one
// synchronous write port and a registered read port with read enable.
// The storage array is not reset; only the read-data register is, so the
// neuron output is a defined zero after reset.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset (read register only)
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read enable; read register holds when low
//   rd_addr_i  read address
//   rd_data_o  registered read data
// ---------------------------------------------------------------------------
module lut_ram_1w1r
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_BITS = DEF_IN_BITS,
    parameter int DATA_BITS = DEF_OUT_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    localparam int DEPTH = lut_depth(ADDR_BITS);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Holding the read register when rd_en_i is low is what keeps the
    // neuron result stable under downstream backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prog_lut_neuron.sv
// ---------------------------------------------------------------------------
// prog_lut_neuron
// Runtime-programmable LUT neuron. A config stream loads all 2^IN_BITS table
// entries in address order; afterwards a valid/ready inference stream looks
// up each input word and returns the registered entry one cycle later.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cfg_start_i  pulse: begin/restart table load at address 0
//   cfg_valid_i  config beat valid
//   cfg_ready_o  config beat accepted when cfg_valid_i && cfg_ready_o
//   cfg_data_i   entry for the current load address
//   cfg_done_o   one-cycle pulse after the final entry is written
//   table_ok_o   level: full table loaded, lookups enabled
//   in_valid_i   inference input valid
//   in_ready_o   inference input accepted
//   in_data_i    neuron input word (table address, unsigned)
//   out_valid_o  lookup result valid
//   out_ready_i  downstream accepts result
//   out_data_o   looked-up entry
// ---------------------------------------------------------------------------
module prog_lut_neuron
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_start_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [OUT_BITS-1:0] cfg_data_i,
    output logic                cfg_done_o,
    output logic                table_ok_o,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_BITS-1:0]  in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUT_BITS-1:0] out_data_o
);

    localparam int             DEPTH     = lut_depth(IN_BITS);
    // One bit wider than the table address so the counter cannot wrap back
    // to a valid address after the final beat.
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IN_BITS:0] addr_q, addr_d;
    logic             cfg_done_q, cfg_done_d;
    logic             out_valid_q, out_valid_d;

    logic             cfg_ready;
    logic             wr_en;
    logic             in_ready;
    logic             accept;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            addr_q      <= '0;
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, load counter and handshakes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cfg_done_d  = 1'b0;
        cfg_ready   = 1'b0;
        wr_en       = 1'b0;
        in_ready    = 1'b0;
        accept      = 1'b0;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_EMPTY: begin
                if (cfg_start_i) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end

            ST_LOAD: begin
                // cfg_start wins over a coincident beat, so the beat is
                // refused rather than silently dropped after acceptance.
                cfg_ready = !cfg_start_i;
                if (cfg_start_i) begin
                    addr_d = '0;
                end else if (cfg_valid_i) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                in_ready = !cfg_start_i && (!out_valid_q || out_ready_i);
                if (cfg_start_i) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end

            default: begin
                state_d = ST_EMPTY;
                addr_d  = '0;
            end
        endcase

        accept = in_valid_i && in_ready;

        // A pending result survives leaving RUN; it only clears on its own
        // handshake, or is replaced by a fresh accept in the same cycle.
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Table storage
    // -----------------------------------------------------------------------
    // Writes only happen in LOAD and reads only in RUN, so there is never a
    // same-address write/read collision to bypass.
    lut_ram_1w1r #(
        .ADDR_BITS (IN_BITS),
        .DATA_BITS (OUT_BITS)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en),
        .wr_addr_i (addr_q[IN_BITS-1:0]),
        .wr_data_i (cfg_data_i),
        .rd_en_i   (accept),
        .rd_addr_i (in_data_i),
        .rd_data_o (out_data_o)
    );

    assign cfg_ready_o = cfg_ready;
    assign cfg_done_o  = cfg_done_q;
    assign table_ok_o  = (state_q == ST_RUN);
    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_prog_lut_neuron.sv
module tb_prog_lut_neuron;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 2;
    localparam int DEPTH    = 256;

    logic                clk;
    logic                rst_n;
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_done;
    logic                table_ok;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;

    int errors = 0;
    int checks = 0;

    logic [OUT_BITS-1:0] exp_tbl [DEPTH];

    prog_lut_neuron #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_start_i (cfg_start),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_data_i  (cfg_data),
        .cfg_done_o  (cfg_done),
        .table_ok_o  (table_ok),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] xor_entry(input logic [7:0] a);
        return a[1:0] ^ a[7:6];
    endfunction

    // Stimulus driver for a table load. Entered and left at posedge+1.
    // Before a restart (restart_at >= 0) the xor pattern is streamed; the
    // full load after it (or the whole load if no restart) uses all_ones.
    task automatic load_table(input bit all_ones, input bit rnd, input int restart_at,
                              output int beats, output int dones, output int done_gap);
        int  a;
        int  cyc;
        int  last_cyc;
        int  done_cyc;
        bit  restarted;
        bit  use_ones;
        a = 0; cyc = 0; last_cyc = -100; done_cyc = -200; restarted = 1'b0;
        beats = 0; dones = 0;
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (a < DEPTH && cyc < 4000) begin
            if (!restarted && restart_at >= 0 && a == restart_at) begin
                cfg_start = 1'b1;
                cfg_valid = 1'b1;
                cfg_data  = 2'b01;
                restarted = 1'b1;
                @(negedge clk);
                cyc++;
                if (cfg_done) begin dones++; done_cyc = cyc; end
                if (cfg_ready) beats++;
                a = 0;
                @(posedge clk); #1;
                cfg_start = 1'b0;
            end else begin
                use_ones  = all_ones && (restart_at < 0 || restarted);
                cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                cfg_data  = use_ones ? 2'b11 : xor_entry(a[7:0]);
                @(negedge clk);
                cyc++;
                if (cfg_done) begin dones++; done_cyc = cyc; end
                if (cfg_valid && cfg_ready) begin
                    beats++;
                    a++;
                    last_cyc = cyc;
                end
                @(posedge clk); #1;
            end
        end
        cfg_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            if (cfg_done) begin dones++; done_cyc = cyc; end
            @(posedge clk); #1;
        end
        done_gap = done_cyc - last_cyc;
        for (int i = 0; i < DEPTH; i++) begin
            exp_tbl[i] = all_ones ? 2'b11 : xor_entry(8'(i));
        end
        $display("load: ones=%0d rnd=%0d restart_at=%0d beats=%0d dones=%0d gap=%0d",
                 all_ones, rnd, restart_at, beats, dones, done_gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cfg_ready, cfg_done, table_ok, in_ready, out_valid, out_data} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {cfg_ready, cfg_done, table_ok, in_ready, out_valid, out_data});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, table_ok, cfg_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL empty_no_lookup cyc %0d: got rdy/ov/ok/cfgrdy=%b expected 0000",
                         c, {in_ready, out_valid, table_ok, cfg_ready});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        $display("reset: empty-state lookup refusal checked for 10 cycles");
    endtask

    task automatic test_load_stream();
        logic [7:0] vin  [4];
        logic [1:0] vexp [4];
        int beats, dones, gap;
        vin  = '{8'h00, 8'h41, 8'hC3, 8'hFF};
        vexp = '{2'b00, 2'b00, 2'b00, 2'b00};
        load_table(1'b0, 1'b0, -1, beats, dones, gap);
        checks++;
        if (beats !== 256) begin errors++; $display("FAIL load_beats: got %0d expected 256", beats); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL load_done_count: got %0d expected 1", dones); end
        checks++;
        if (gap !== 1) begin errors++; $display("FAIL load_done_latency: got %0d expected 1", gap); end
        checks++;
        if (table_ok !== 1'b1) begin errors++; $display("FAIL load_table_ok: got %b expected 1", table_ok); end
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = vin[i];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready %0d: got %b expected 1", i, in_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== vexp[i-1]) begin
                    errors++;
                    $display("FAIL stream_out %0d: got v=%b d=%b expected v=1 d=%b",
                             i - 1, out_valid, out_data, vexp[i-1]);
                end
                $display("lookup: in=%h out=%b", vin[i-1], out_data);
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_no_early_valid: got %b expected 0", out_valid);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_readback(input string label);
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) begin
                in_valid = 1'b1;
                in_data  = 8'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_tbl[i-1]) begin
                    errors++;
                    bad++;
                    $display("FAIL %s addr %0h: got v=%b d=%b expected v=1 d=%b",
                             label, i - 1, out_valid, out_data, exp_tbl[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        $display("readback %s: 256 addresses, %0d wrong", label, bad);
    endtask

    task automatic test_random_load();
        int beats, dones, gap;
        load_table(1'b0, 1'b1, -1, beats, dones, gap);
        checks++;
        if (beats !== 256) begin errors++; $display("FAIL rnd_beats: got %0d expected 256", beats); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL rnd_done_count: got %0d expected 1", dones); end
        checks++;
        if (gap !== 1) begin errors++; $display("FAIL rnd_done_latency: got %0d expected 1", gap); end
        test_readback("rnd_readback");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_accept: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_data = 8'h42;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 2'b00 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold %0d: got v=%b d=%b rdy=%b expected v=1 d=00 rdy=0",
                         c, out_valid, out_data, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 2'b00) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b v=%b d=%b expected rdy=1 v=1 d=00",
                     in_ready, out_valid, out_data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 2'b11) begin
            errors++;
            $display("FAIL bp_next_result: got v=%b d=%b expected v=1 d=11", out_valid, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
        end
        @(posedge clk); #1;
        $display("backpressure: 41 held 3 cycles, 42 accepted on release");
    endtask

    task automatic test_restart_load();
        int beats, dones, gap;
        load_table(1'b1, 1'b0, 100, beats, dones, gap);
        checks++;
        if (beats !== 356) begin errors++; $display("FAIL restart_beats: got %0d expected 356", beats); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", dones); end
        checks++;
        if (gap !== 1) begin errors++; $display("FAIL restart_done_latency: got %0d expected 1", gap); end
        test_readback("ones_readback");
    endtask

    task automatic test_async_reset();
        int beats, dones, gap;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_accept: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 2'b11) begin
            errors++;
            $display("FAIL ar_pending: got v=%b d=%b expected v=1 d=11", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || table_ok !== 1'b0 || out_data !== 2'b00) begin
            errors++;
            $display("FAIL ar_async_clear: got v=%b ok=%b d=%b expected v=0 ok=0 d=00",
                     out_valid, table_ok, out_data);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h03;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || table_ok !== 1'b0) begin
                errors++;
                $display("FAIL ar_refused %0d: got rdy=%b v=%b ok=%b expected 0 0 0",
                         c, in_ready, out_valid, table_ok);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        load_table(1'b0, 1'b0, -1, beats, dones, gap);
        checks++;
        if (beats !== 256 || dones !== 1) begin
            errors++;
            $display("FAIL ar_reload: got beats=%0d dones=%0d expected 256 1", beats, dones);
        end
        in_valid = 1'b1;
        in_data  = 8'h03;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_post_accept: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 2'b11) begin
            errors++;
            $display("FAIL ar_post_lookup: got v=%b d=%b expected v=1 d=11", out_valid, out_data);
        end
        $display("lookup: in=03 out=%b after reset and reload", out_data);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_random_load();
        test_backpressure();
        test_restart_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
